// File: rtl/cassette_tone_gen.sv
// CUTS cassette tone generator: frames bytes (start 0, 8 data LSB first, stop 1) into a
// 1200/2400 Hz square wave, preceded by a high-tone leader, for the ULA CasIn input.
module cassette_tone_gen #(
    parameter int unsigned HALF_CLKS   = 256,
    parameter int unsigned LEADER_BITS = 480
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       motor,
    input  logic       leader_req,
    input  logic [7:0] byte_data,
    input  logic       byte_valid,
    output logic       byte_ready,
    output logic       cas_out,
    output logic       in_leader,
    output logic       busy
);

    localparam int unsigned HW = (HALF_CLKS > 1) ? $clog2(HALF_CLKS) : 1;
    localparam logic [HW-1:0] HALF_LAST   = HW'(HALF_CLKS - 1);
    localparam logic [15:0]   LEADER_LAST = 16'(LEADER_BITS - 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_LEADER  = 2'd1;
    localparam logic [1:0] ST_CARRIER = 2'd2;
    localparam logic [1:0] ST_FRAME   = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [HW-1:0] half_q, half_d;
    logic [1:0]    seg_q, seg_d;
    logic [15:0]   leader_cnt_q, leader_cnt_d;
    logic [3:0]    bit_idx_q, bit_idx_d;
    logic [9:0]    shift_q, shift_d;
    logic          cas_q, cas_d;

    logic half_end;
    logic boundary;
    logic cur_bit;
    logic accept;

    assign half_end = (state_q != ST_IDLE) && (half_q == HALF_LAST);
    assign boundary = half_end && (seg_q == 2'd3);
    assign cur_bit  = (state_q == ST_FRAME) ? shift_q[0] : 1'b1;

    // Offered only at bit boundaries; gated by motor so a byte is never taken just as we stop.
    assign byte_ready = motor && boundary &&
                        (((state_q == ST_CARRIER) && !leader_req) ||
                         ((state_q == ST_FRAME) && (bit_idx_q == 4'd9)));
    assign accept     = byte_ready && byte_valid;

    always_comb begin
        state_d      = state_q;
        half_d       = half_q;
        seg_d        = seg_q;
        leader_cnt_d = leader_cnt_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        cas_d        = cas_q;

        if (state_q != ST_IDLE) begin
            half_d = half_end ? '0 : HW'(half_q + 1'b1);
            if (half_end) begin
                seg_d = seg_q + 2'd1;
                // A 1 toggles every segment; a 0 only at the end of seg 1 and seg 3.
                if (cur_bit || seg_q[0]) begin
                    cas_d = ~cas_q;
                end
            end
        end

        case (state_q)
            ST_IDLE: begin
                cas_d = 1'b0;
                if (motor) begin
                    state_d      = ST_LEADER;
                    leader_cnt_d = '0;
                end
            end
            ST_LEADER: begin
                if (boundary) begin
                    if (leader_cnt_q == LEADER_LAST) begin
                        state_d = ST_CARRIER;
                    end else begin
                        leader_cnt_d = leader_cnt_q + 16'd1;
                    end
                end
            end
            ST_CARRIER: begin
                if (boundary) begin
                    if (leader_req) begin
                        state_d      = ST_LEADER;
                        leader_cnt_d = '0;
                    end else if (accept) begin
                        state_d   = ST_FRAME;
                        shift_d   = {1'b1, byte_data, 1'b0};
                        bit_idx_d = '0;
                    end
                end
            end
            ST_FRAME: begin
                if (boundary) begin
                    if (bit_idx_q == 4'd9) begin
                        if (accept) begin
                            shift_d   = {1'b1, byte_data, 1'b0};
                            bit_idx_d = '0;
                        end else begin
                            state_d = ST_CARRIER;
                        end
                    end else begin
                        shift_d   = {1'b0, shift_q[9:1]};
                        bit_idx_d = bit_idx_q + 4'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (!motor) begin
            state_d      = ST_IDLE;
            half_d       = '0;
            seg_d        = '0;
            leader_cnt_d = '0;
            bit_idx_d    = '0;
            cas_d        = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            half_q       <= '0;
            seg_q        <= '0;
            leader_cnt_q <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            cas_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            half_q       <= half_d;
            seg_q        <= seg_d;
            leader_cnt_q <= leader_cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            cas_q        <= cas_d;
        end
    end

    assign cas_out   = cas_q;
    assign in_leader = (state_q == ST_LEADER);
    assign busy      = (state_q == ST_FRAME);

endmodule

// File: tb/tb_cassette_tone_gen.sv
// Directed bench for cassette_tone_gen with HALF_CLKS=4, LEADER_BITS=2 (16 clocks per bit).
module tb_cassette_tone_gen;

    logic       clk;
    logic       reset;
    logic       motor;
    logic       leader_req;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       byte_ready;
    logic       cas_out;
    logic       in_leader;
    logic       busy;

    int errors = 0;
    int checks = 0;

    // Frame bit patterns, index i = bit_idx (start, data LSB first, stop).
    logic [9:0] bits_a5 = 10'b1101001010;
    logic [9:0] bits_00 = 10'b1000000000;
    logic [9:0] bits_ff = 10'b1111111110;
    logic [9:0] bits_3c = 10'b1001111000;
    logic [9:0] bits_81 = 10'b1100000010;

    cassette_tone_gen #(
        .HALF_CLKS  (4),
        .LEADER_BITS(2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .motor     (motor),
        .leader_req(leader_req),
        .byte_data (byte_data),
        .byte_valid(byte_valid),
        .byte_ready(byte_ready),
        .cas_out   (cas_out),
        .in_leader (in_leader),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Starting at leader cycle 0: 32 leader cycles, then carrier with ready every 16th cycle.
    task automatic leader_run(input string ph, input int n);
        for (int k = 0; k < n; k++) begin
            chk($sformatf("%s k%0d in_leader", ph, k), in_leader, k < 32);
            chk($sformatf("%s k%0d cas", ph, k), cas_out, (k >> 2) & 1);
            chk($sformatf("%s k%0d ready", ph, k), byte_ready, (k >= 32) && (k % 16 == 15));
            chk($sformatf("%s k%0d busy", ph, k), busy, 0);
            tick(1);
        end
    endtask

    // One carrier bit from its first cycle.
    task automatic carrier_bit(input string ph, input logic exp_ready);
        for (int j = 0; j < 16; j++) begin
            chk($sformatf("%s c%0d in_leader", ph, j), in_leader, 0);
            chk($sformatf("%s c%0d busy", ph, j), busy, 0);
            chk($sformatf("%s c%0d cas", ph, j), cas_out, (j >> 2) & 1);
            chk($sformatf("%s c%0d ready", ph, j), byte_ready, (j == 15) && exp_ready);
            tick(1);
        end
    endtask

    task automatic frame_run(input string ph, input logic [9:0] bits, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            for (int j = 0; j < 16; j++) begin
                chk($sformatf("%s b%0d c%0d busy", ph, i, j), busy, 1);
                chk($sformatf("%s b%0d c%0d in_leader", ph, i, j), in_leader, 0);
                chk($sformatf("%s b%0d c%0d cas", ph, i, j), cas_out,
                    bits[i] ? ((j >> 2) & 1) : ((j >> 3) & 1));
                chk($sformatf("%s b%0d c%0d ready", ph, i, j), byte_ready,
                    (i == 9) && (j == 15));
                tick(1);
            end
        end
    endtask

    initial begin
        reset      = 1'b1;
        motor      = 1'b0;
        leader_req = 1'b0;
        byte_data  = 8'h00;
        byte_valid = 1'b0;
        tick(2);
        chk("rst cas", cas_out, 0);
        chk("rst ready", byte_ready, 0);
        chk("rst in_leader", in_leader, 0);
        chk("rst busy", busy, 0);

        reset = 1'b0;
        tick(3);
        chk("idle cas", cas_out, 0);
        chk("idle in_leader", in_leader, 0);

        // Leader then carrier, no bytes.
        motor = 1'b1;
        tick(1);
        leader_run("lead", 64);

        // Single byte 0xA5 from carrier.
        byte_data  = 8'hA5;
        byte_valid = 1'b1;
        carrier_bit("a5 acc", 1'b1);
        byte_valid = 1'b0;
        frame_run("a5", bits_a5, 10);
        chk("a5 done busy", busy, 0);

        // Back-to-back 0x00 then 0xFF.
        byte_data  = 8'h00;
        byte_valid = 1'b1;
        carrier_bit("b2b acc", 1'b1);
        byte_data = 8'hFF;
        frame_run("b2b 00", bits_00, 10);
        byte_valid = 1'b0;
        frame_run("b2b ff", bits_ff, 10);
        chk("b2b done busy", busy, 0);

        // leader_req beats byte_valid at the same boundary.
        leader_req = 1'b1;
        byte_data  = 8'h3C;
        byte_valid = 1'b1;
        carrier_bit("prio", 1'b0);
        leader_req = 1'b0;
        leader_run("prio lead", 48);
        byte_valid = 1'b0;
        frame_run("3c", bits_3c, 4);

        // Motor loss in bit_idx 4.
        tick(5);
        chk("mloss pre cas", cas_out, 1);
        chk("mloss pre busy", busy, 1);
        motor = 1'b0;
        tick(1);
        chk("mloss cas", cas_out, 0);
        chk("mloss busy", busy, 0);
        chk("mloss ready", byte_ready, 0);
        chk("mloss in_leader", in_leader, 0);

        // Motor back: full leader before the pending byte is taken.
        byte_data  = 8'h81;
        byte_valid = 1'b1;
        motor      = 1'b1;
        tick(1);
        leader_run("remot", 48);
        byte_valid = 1'b0;
        frame_run("81", bits_81, 10);
        chk("81 done busy", busy, 0);

        // Asynchronous reset in the middle of a leader.
        leader_req = 1'b1;
        carrier_bit("rl req", 1'b0);
        leader_req = 1'b0;
        leader_run("rl pre", 20);
        chk("rl pre cas", cas_out, 1);
        chk("rl pre in_leader", in_leader, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("arst cas", cas_out, 0);
        chk("arst in_leader", in_leader, 0);
        chk("arst busy", busy, 0);
        chk("arst ready", byte_ready, 0);
        tick(2);
        reset = 1'b0;
        tick(1);
        leader_run("rl post", 40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
